// File: rtl/evt_pkt_writer_pkg.sv
// Shared definitions for the event-capture packet writer: state encoding,
// last-word ctrl codes and helpers for packing event records into datapath words.
package evt_capture_defines;

    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff;
    localparam logic [7:0] CTRL_LAST_FULL     = 8'h01;
    localparam logic [7:0] CTRL_LAST_HALF     = 8'h08;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_CHK_WAIT = 3'd2,
        ST_HDR      = 3'd3,
        ST_ABS      = 3'd4,
        ST_EVTS     = 3'd5,
        ST_DONE     = 3'd6
    } wr_state_e;

    // The older event occupies the upper half; a lone trailing event is zero-padded.
    function automatic logic [63:0] pack_evt_pair(input logic [31:0] first_evt,
                                                  input logic [31:0] second_evt,
                                                  input logic        single);
        return {first_evt, (single ? 32'h0000_0000 : second_evt)};
    endfunction

    function automatic logic [7:0] last_evt_ctrl(input logic single);
        return single ? CTRL_LAST_HALF : CTRL_LAST_FULL;
    endfunction

endpackage

// File: rtl/evt_pkt_writer_if.sv
// NetFPGA-style datapath output bus from the packet writer into the output-queue merge.
interface evt_pkt_writer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;

    modport master (output out_data, output out_ctrl, output out_wr, input  out_rdy);
    modport slave  (input  out_data, input  out_ctrl, input  out_wr, output out_rdy);
endinterface

// File: rtl/evt_pkt_writer_fifo.sv
// 32-bit event FIFO with occupancy count, flush, and a two-entry lookahead so
// a pair of events can be popped in one cycle.
module evt_fifo #(
    parameter int DEPTH_BITS = 9
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                wr_en,
    input  logic [31:0]         wr_data,
    input  logic [1:0]          pop_cnt,
    output logic [31:0]         rd_data0,
    output logic [31:0]         rd_data1,
    output logic [DEPTH_BITS:0] count,
    output logic                full,
    output logic                empty
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CNT_W = DEPTH_BITS + 1;

    logic [31:0]           mem_r [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_r;
    logic [DEPTH_BITS-1:0] rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_s;
    logic                  wr_ok_s;
    logic [1:0]            pop_ok_s;

    // Qualify write and pop requests against occupancy and flush.
    always_comb begin
        full_s   = (count_r == CNT_W'(DEPTH));
        wr_ok_s  = wr_en && !full_s && !flush;
        pop_ok_s = (!flush && (CNT_W'(pop_cnt) <= count_r)) ? pop_cnt : 2'd0;
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_r + DEPTH_BITS'(wr_ok_s);
            rd_ptr_r <= rd_ptr_r + DEPTH_BITS'(pop_ok_s);
            count_r  <= count_r + CNT_W'(wr_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    assign rd_data0 = mem_r[rd_ptr_r];
    assign rd_data1 = mem_r[rd_ptr_r + DEPTH_BITS'(1)];
    assign count    = count_r;
    assign full     = full_s;
    assign empty    = (count_r == '0);

endmodule

// File: rtl/evt_pkt_writer.sv
// Event packetiser: buffers event records and emits header, absolute-timer and
// packed-event words onto the datapath output when a send is triggered.
module evt_pkt_writer
    import evt_capture_defines::*;
#(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int HEADER_LENGTH       = 7,
    parameter int HEADER_LENGTH_SIZE  = 3,
    parameter int NUM_ABS_REG_PAIRS   = 4,
    parameter int EVT_FIFO_DEPTH_BITS = 9,
    parameter int MAX_EVTS_PER_PKT    = 256
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [31:0]                     evt_data,
    input  logic                            evt_valid,
    output logic                            evt_fifo_full,
    input  logic [64*NUM_ABS_REG_PAIRS-1:0] abs_timers,
    input  logic                            send_pkt,
    input  logic                            enable_events,
    output logic [HEADER_LENGTH_SIZE-1:0]   header_word_number,
    input  logic [DATA_WIDTH-1:0]           header_data,
    input  logic [CTRL_WIDTH-1:0]           header_ctrl,
    output logic [8:0]                      num_evts_in_pkt,
    output logic                            evt_pkt_sent,
    evt_pkt_writer_if.master                out_if
);
    localparam int CNT_W     = EVT_FIFO_DEPTH_BITS + 1;
    localparam int ABS_IDX_W = (NUM_ABS_REG_PAIRS > 1) ? $clog2(NUM_ABS_REG_PAIRS) : 1;

    wr_state_e                       state_r;
    logic                            send_prev_r;
    logic                            send_pend_r;
    logic [8:0]                      num_evts_r;
    logic [8:0]                      evts_left_r;
    logic [1:0]                      wait_cnt_r;
    logic [HEADER_LENGTH_SIZE-1:0]   hdr_idx_r;
    logic [ABS_IDX_W-1:0]            abs_idx_r;
    logic [64*NUM_ABS_REG_PAIRS-1:0] abs_snap_r;
    logic [DATA_WIDTH-1:0]           out_data_r;
    logic [CTRL_WIDTH-1:0]           out_ctrl_r;
    logic                            out_wr_r;
    logic                            evt_pkt_sent_r;

    logic [CNT_W-1:0]      fifo_count_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [31:0]           fifo_d0_s;
    logic [31:0]           fifo_d1_s;
    logic                  fifo_flush_s;
    logic [1:0]            pop_cnt_s;
    logic                  send_edge_s;
    logic                  trigger_s;
    logic                  hdr_last_s;
    logic                  abs_last_s;
    logic                  evts_single_s;
    logic [63:0]           abs_word_s;
    logic                  word_valid_s;
    logic                  word_last_s;
    logic [DATA_WIDTH-1:0] word_data_s;
    logic [CTRL_WIDTH-1:0] word_ctrl_s;
    logic                  wr_go_s;

    evt_fifo #(.DEPTH_BITS(EVT_FIFO_DEPTH_BITS)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (fifo_flush_s),
        .wr_en    (evt_valid),
        .wr_data  (evt_data),
        .pop_cnt  (pop_cnt_s),
        .rd_data0 (fifo_d0_s),
        .rd_data1 (fifo_d1_s),
        .count    (fifo_count_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s)
    );

    // Next output word for the current state and the pops that go with it.
    always_comb begin
        send_edge_s   = send_pkt && !send_prev_r;
        trigger_s     = (fifo_count_s >= CNT_W'(MAX_EVTS_PER_PKT)) || send_pend_r || send_edge_s;
        fifo_flush_s  = (state_r == ST_IDLE) && !enable_events;
        hdr_last_s    = (hdr_idx_r == HEADER_LENGTH_SIZE'(HEADER_LENGTH - 1));
        abs_last_s    = (abs_idx_r == ABS_IDX_W'(NUM_ABS_REG_PAIRS - 1));
        evts_single_s = (evts_left_r == 9'd1);
        abs_word_s    = 64'd0;
        for (int i = 0; i < NUM_ABS_REG_PAIRS; i++) begin
            abs_word_s = (abs_idx_r == ABS_IDX_W'(i)) ? abs_snap_r[i*64 +: 64] : abs_word_s;
        end
        word_valid_s = 1'b0;
        word_last_s  = 1'b0;
        word_data_s  = '0;
        word_ctrl_s  = '0;
        case (state_r)
            ST_HDR: begin
                word_valid_s = 1'b1;
                word_last_s  = hdr_last_s && (NUM_ABS_REG_PAIRS == 0) && (num_evts_r == 9'd0);
                word_data_s  = header_data;
                word_ctrl_s  = word_last_s ? CTRL_WIDTH'(CTRL_LAST_FULL) : header_ctrl;
            end
            ST_ABS: begin
                word_valid_s = 1'b1;
                word_last_s  = abs_last_s && (num_evts_r == 9'd0);
                word_data_s  = DATA_WIDTH'(abs_word_s);
                word_ctrl_s  = word_last_s ? CTRL_WIDTH'(CTRL_LAST_FULL) : CTRL_WIDTH'(8'h00);
            end
            ST_EVTS: begin
                word_valid_s = !fifo_empty_s;
                word_last_s  = (evts_left_r <= 9'd2);
                word_data_s  = DATA_WIDTH'(pack_evt_pair(fifo_d0_s, fifo_d1_s, evts_single_s));
                word_ctrl_s  = word_last_s ? CTRL_WIDTH'(last_evt_ctrl(evts_single_s))
                                           : CTRL_WIDTH'(8'h00);
            end
            default: begin
                word_valid_s = 1'b0;
            end
        endcase
        wr_go_s   = word_valid_s && out_if.out_rdy;
        pop_cnt_s = (wr_go_s && (state_r == ST_EVTS)) ? (evts_single_s ? 2'd1 : 2'd2) : 2'd0;
    end

    // Packet sequencer with registered datapath outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            send_prev_r    <= 1'b0;
            send_pend_r    <= 1'b0;
            num_evts_r     <= 9'd0;
            evts_left_r    <= 9'd0;
            wait_cnt_r     <= 2'd0;
            hdr_idx_r      <= '0;
            abs_idx_r      <= '0;
            abs_snap_r     <= '0;
            out_data_r     <= '0;
            out_ctrl_r     <= '0;
            out_wr_r       <= 1'b0;
            evt_pkt_sent_r <= 1'b0;
        end else begin
            send_prev_r    <= send_pkt;
            out_wr_r       <= wr_go_s;
            evt_pkt_sent_r <= wr_go_s && word_last_s;
            if (wr_go_s) begin
                out_data_r <= word_data_s;
                out_ctrl_r <= word_ctrl_s;
            end
            // An edge seen mid-packet stays pending until IDLE consumes it.
            if (send_edge_s) begin
                send_pend_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (!enable_events) begin
                        send_pend_r <= 1'b0;
                    end else if (trigger_s) begin
                        send_pend_r <= 1'b0;
                        state_r     <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    num_evts_r  <= (fifo_count_s >= CNT_W'(MAX_EVTS_PER_PKT)) ?
                                   9'(MAX_EVTS_PER_PKT) : 9'(fifo_count_s);
                    evts_left_r <= (fifo_count_s >= CNT_W'(MAX_EVTS_PER_PKT)) ?
                                   9'(MAX_EVTS_PER_PKT) : 9'(fifo_count_s);
                    abs_snap_r  <= abs_timers;
                    wait_cnt_r  <= 2'd0;
                    hdr_idx_r   <= '0;
                    abs_idx_r   <= '0;
                    state_r     <= ST_CHK_WAIT;
                end
                ST_CHK_WAIT: begin
                    wait_cnt_r <= wait_cnt_r + 2'd1;
                    state_r    <= (wait_cnt_r == 2'd2) ? ST_HDR : ST_CHK_WAIT;
                end
                ST_HDR: begin
                    if (wr_go_s) begin
                        hdr_idx_r <= hdr_last_s ? '0 : hdr_idx_r + HEADER_LENGTH_SIZE'(1);
                        if (hdr_last_s) begin
                            state_r <= (NUM_ABS_REG_PAIRS > 0) ? ST_ABS :
                                       ((num_evts_r == 9'd0) ? ST_DONE : ST_EVTS);
                        end
                    end
                end
                ST_ABS: begin
                    if (wr_go_s) begin
                        abs_idx_r <= abs_last_s ? '0 : abs_idx_r + ABS_IDX_W'(1);
                        if (abs_last_s) begin
                            state_r <= (num_evts_r == 9'd0) ? ST_DONE : ST_EVTS;
                        end
                    end
                end
                ST_EVTS: begin
                    if (wr_go_s) begin
                        evts_left_r <= evts_left_r - 9'(pop_cnt_s);
                        if (word_last_s) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt_fifo_full      = fifo_full_s;
    assign header_word_number = hdr_idx_r;
    assign num_evts_in_pkt    = num_evts_r;
    assign evt_pkt_sent       = evt_pkt_sent_r;
    assign out_if.out_data    = out_data_r;
    assign out_if.out_ctrl    = out_ctrl_r;
    assign out_if.out_wr      = out_wr_r;

endmodule

// File: tb/tb_evt_pkt_writer.sv
// Directed-sequence bench for evt_pkt_writer with random event/timer/header data;
// expected packets come from a queue model of accepted events.
module tb_evt_pkt_writer;

    localparam int HL   = 7;
    localparam int NABS = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  evt_data = 32'd0;
    logic         evt_valid = 1'b0;
    logic         evt_fifo_full;
    logic [255:0] abs_timers = 256'd0;
    logic         send_pkt = 1'b0;
    logic         enable_events = 1'b1;
    logic [2:0]   header_word_number;
    logic [63:0]  header_data;
    logic [7:0]   header_ctrl;
    logic [8:0]   num_evts_in_pkt;
    logic         evt_pkt_sent;

    evt_pkt_writer_if #(.DATA_WIDTH(64)) out_if ();

    evt_pkt_writer dut (
        .clk                (clk),
        .reset              (reset),
        .evt_data           (evt_data),
        .evt_valid          (evt_valid),
        .evt_fifo_full      (evt_fifo_full),
        .abs_timers         (abs_timers),
        .send_pkt           (send_pkt),
        .enable_events      (enable_events),
        .header_word_number (header_word_number),
        .header_data        (header_data),
        .header_ctrl        (header_ctrl),
        .num_evts_in_pkt    (num_evts_in_pkt),
        .evt_pkt_sent       (evt_pkt_sent),
        .out_if             (out_if)
    );

    always #5 clk = ~clk;

    logic [63:0] hdr_words [8];
    logic [63:0] abs_vals [NABS];
    assign header_data = hdr_words[header_word_number];
    assign header_ctrl = (header_word_number == 3'd0) ? 8'hFF : {5'd0, header_word_number};

    int checks = 0;
    int failures = 0;
    int sent_cnt = 0;
    int bad_wr = 0;
    int exp_sent = 0;
    logic rdy_prev = 1'b0;
    logic [63:0] cap_d [$];
    logic [7:0]  cap_c [$];
    logic [63:0] exp_d [$];
    logic [7:0]  exp_c [$];
    logic [31:0] model_q [$];

    always @(posedge clk) rdy_prev <= out_if.out_rdy;

    always @(negedge clk) begin
        if (out_if.out_wr) begin
            cap_d.push_back(out_if.out_data);
            cap_c.push_back(out_if.out_ctrl);
            if (!rdy_prev) bad_wr++;
        end
        if (evt_pkt_sent) sent_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_one(input logic [31:0] d);
        @(negedge clk);
        evt_valid = 1'b1;
        evt_data  = d;
        if (model_q.size() < 512) model_q.push_back(d);
    endtask

    task automatic push_evts(input int n);
        for (int i = 0; i < n; i++) push_one($urandom);
        @(negedge clk);
        evt_valid = 1'b0;
    endtask

    task automatic send_edge();
        @(negedge clk);
        send_pkt = 1'b1;
        @(negedge clk);
        send_pkt = 1'b0;
    endtask

    task automatic new_abs();
        for (int j = 0; j < NABS; j++) begin
            abs_vals[j] = {$urandom, $urandom};
            abs_timers[j*64 +: 64] = abs_vals[j];
        end
    endtask

    task automatic wait_sent(input string tag, input int budget);
        int n;
        n = 0;
        while (sent_cnt < exp_sent && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, 64'(sent_cnt >= exp_sent), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_hwn(input string tag, input int v);
        int n;
        n = 0;
        while (header_word_number != 3'(v) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(header_word_number), 64'(v));
    endtask

    // Expected packet: headers, timer snapshot, then events in pairs from the model queue.
    task automatic build_exp(input int nev);
        int rem;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < HL; i++) begin
            exp_d.push_back(hdr_words[i]);
            exp_c.push_back((i == 0) ? 8'hFF : 8'(i));
        end
        for (int j = 0; j < NABS; j++) begin
            exp_d.push_back(abs_vals[j]);
            exp_c.push_back((j == NABS - 1 && nev == 0) ? 8'h01 : 8'h00);
        end
        rem = nev;
        while (rem > 0) begin
            a = model_q.pop_front();
            if (rem == 1) begin
                b = 32'd0;
                rem = 0;
            end else begin
                b = model_q.pop_front();
                rem -= 2;
            end
            exp_d.push_back({a, b});
            exp_c.push_back((rem == 0) ? ((nev % 2 == 1) ? 8'h08 : 8'h01) : 8'h00);
        end
    endtask

    task automatic cmp_pkt(input string tag);
        int mism;
        int lim;
        mism = 0;
        lim = (cap_d.size() < exp_d.size()) ? cap_d.size() : exp_d.size();
        chk({tag, "_len"}, 64'(cap_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < lim; i++) begin
            if (cap_d[i] !== exp_d[i] || cap_c[i] !== exp_c[i]) mism++;
        end
        chk({tag, "_words"}, 64'(mism), 64'd0);
        if (lim > 0) chk({tag, "_lastctrl"}, 64'(cap_c[cap_c.size()-1]), 64'(exp_c[exp_c.size()-1]));
        chk({tag, "_sent"}, 64'(sent_cnt), 64'(exp_sent));
        chk({tag, "_rdy_wr"}, 64'(bad_wr), 64'd0);
        cap_d.delete(); cap_c.delete(); exp_d.delete(); exp_c.delete();
    endtask

    initial begin
        logic pat [10];
        int ones;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        out_if.out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) hdr_words[i] = {$urandom, $urandom};
        new_abs();
        repeat (3) @(negedge clk);
        chk("rst_out_wr", 64'(out_if.out_wr), 64'd0);
        chk("rst_out_data", out_if.out_data, 64'd0);
        chk("rst_out_ctrl", 64'(out_if.out_ctrl), 64'd0);
        chk("rst_sent", 64'(evt_pkt_sent), 64'd0);
        chk("rst_num", 64'(num_evts_in_pkt), 64'd0);
        chk("rst_hwn", 64'(header_word_number), 64'd0);
        chk("rst_full", 64'(evt_fifo_full), 64'd0);
        reset = 1'b0;

        // 256 events trigger an automatic send
        push_evts(256);
        exp_sent = 1;
        wait_sent("big_wait", 2000);
        build_exp(256);
        cmp_pkt("big");
        chk("big_num", 64'(num_evts_in_pkt), 64'd256);

        // odd count, forced send
        new_abs();
        push_evts(3);
        send_edge();
        exp_sent++;
        wait_sent("odd_wait", 500);
        build_exp(3);
        cmp_pkt("odd");
        chk("odd_num", 64'(num_evts_in_pkt), 64'd3);

        // forced send with empty FIFO
        new_abs();
        send_edge();
        exp_sent++;
        wait_sent("empty_wait", 500);
        build_exp(0);
        cmp_pkt("empty");
        chk("empty_num", 64'(num_evts_in_pkt), 64'd0);

        // out_rdy throttling through the header
        new_abs();
        push_evts(4);
        out_if.out_rdy = 1'b0;
        send_edge();
        repeat (8) @(negedge clk);
        ones = 0;
        for (int p = 0; p < 10; p++) begin
            out_if.out_rdy = pat[p];
            @(negedge clk);
            ones += int'(pat[p]);
            chk("thr_hwn", 64'(header_word_number), 64'(ones));
        end
        out_if.out_rdy = 1'b1;
        exp_sent++;
        wait_sent("thr_wait", 500);
        build_exp(4);
        cmp_pkt("thr");

        // fill to 512 while stalled; 513th event is dropped
        new_abs();
        out_if.out_rdy = 1'b0;
        push_evts(512);
        chk("fill_full", 64'(evt_fifo_full), 64'd1);
        push_one(32'hDEAD_BEEF);
        @(negedge clk);
        evt_valid = 1'b0;
        chk("fill_full2", 64'(evt_fifo_full), 64'd1);
        out_if.out_rdy = 1'b1;
        exp_sent += 2;
        wait_sent("fill_wait", 4000);
        build_exp(256);
        build_exp(256);
        cmp_pkt("fill");
        chk("fill_notfull", 64'(evt_fifo_full), 64'd0);

        // disable mid-packet: packet completes, then flush
        new_abs();
        push_evts(10);
        send_edge();
        wait_hwn("dis_hwn", 1);
        enable_events = 1'b0;
        push_evts(3);
        exp_sent++;
        wait_sent("dis_wait", 500);
        build_exp(10);
        cmp_pkt("dis");
        model_q.delete();
        send_edge();
        repeat (30) @(negedge clk);
        chk("dis_ignored", 64'(sent_cnt), 64'(exp_sent));
        chk("dis_nowords", 64'(cap_d.size()), 64'd0);
        enable_events = 1'b1;
        repeat (20) @(negedge clk);
        chk("dis_nopend", 64'(sent_cnt), 64'(exp_sent));
        send_edge();
        exp_sent++;
        wait_sent("flush_wait", 500);
        build_exp(0);
        cmp_pkt("flush");

        // reset mid-packet aborts without a sent pulse
        push_evts(4);
        send_edge();
        wait_hwn("abort_hwn", 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_sent", 64'(sent_cnt), 64'(exp_sent));
        chk("abort_num", 64'(num_evts_in_pkt), 64'd0);
        chk("abort_wr", 64'(out_if.out_wr), 64'd0);
        model_q.delete();
        cap_d.delete(); cap_c.delete();
        send_edge();
        exp_sent++;
        wait_sent("abort_after_wait", 500);
        build_exp(0);
        cmp_pkt("abort_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
